// File: rtl/mult_pkg.sv
// Shared types and constants for the Baugh-Wooley multiplier family.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Correction term 2^dw + 2^(2*dw-1); the caller truncates to 2*dw bits.
  function automatic logic [127:0] bw_const(input int dw);
    logic [127:0] c;
    c = (128'd1 << dw) | (128'd1 << (2 * dw - 1));
    return c;
  endfunction

endpackage

// File: rtl/bw_pprow.sv
// One Baugh-Wooley partial-product row: AND terms with the sign column inverted.
module bw_pprow #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] muld,
  input  logic          mulr_bit,
  input  logic          last_row,
  output logic [DW-1:0] row
);

  logic [DW-1:0] and_row;
  logic [DW-1:0] inv_mask;

  assign and_row = muld & {DW{mulr_bit}};
  // Ordinary rows invert only the MSB term; the sign row inverts all but the MSB.
  assign inv_mask = last_row ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
  assign row = and_row ^ inv_mask;

endmodule

// File: rtl/bw_mult_seq.sv
// Iterative signed Baugh-Wooley multiplier: one partial-product row added per cycle.
module bw_mult_seq
  import mult_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   muld,
  input  logic [DW-1:0]   mulr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW);
  localparam int PW = 2 * DW;
  localparam logic [PW-1:0] BWC = PW'(bw_const(DW));
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] muld_q, muld_d;
  logic [DW-1:0] mulr_q, mulr_d;
  logic [PW-1:0] acc_q, acc_d;

  logic [DW-1:0] row;
  logic [PW-1:0] row_sh;
  logic          last_row;

  assign last_row = (cnt_q == LAST);

  bw_pprow #(.DW(DW)) u_pprow (
    .muld     (muld_q),
    .mulr_bit (mulr_q[cnt_q]),
    .last_row (last_row),
    .row      (row)
  );

  assign row_sh = PW'(row) << cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    muld_d  = muld_q;
    mulr_d  = mulr_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          muld_d  = muld;
          mulr_d  = mulr;
          acc_d   = BWC;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + row_sh;
        if (last_row) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      muld_q  <= '0;
      mulr_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      muld_q  <= muld_d;
      mulr_q  <= mulr_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_bw_mult_seq.sv
// Scoreboard bench for bw_mult_seq: directed corners, backpressure, reset, random traffic.
module tb_bw_mult_seq;

  localparam int DW = 8;
  localparam int NRAND = 2000;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   muld;
  logic [DW-1:0]   mulr;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] product;

  bw_mult_seq #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .muld      (muld),
    .mulr      (mulr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int n_in = 0;
  int n_out = 0;
  logic [2*DW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(product), 32'hFFFF_FFFF);
      end else begin
        chk("product", 32'(product), 32'(sb.pop_front()));
      end
      n_out++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2*DW-1:0] e);
    int k;
    muld = a;
    mulr = b;
    in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      sb.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges from the accept edge to the first edge sampling out_valid=1.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0]   sa, sbv;
    logic signed [2*DW-1:0] p;
    sa = a;
    sbv = b;
    p = sa * sbv;
    return p;
  endfunction

  logic [DW-1:0]   ca[5] = '{8'h80, 8'h7F, 8'h7F, 8'h00, 8'hFF};
  logic [DW-1:0]   cb[5] = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'hFF};
  logic [2*DW-1:0] ce[5] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'h0001};

  initial begin
    int lat;
    bit drv_done;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    muld = '0;
    mulr = '0;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    step();

    // 5 * -3 with latency and turnaround checks
    send(8'd5, 8'hFD, 16'hFFF1);
    chk("in_ready_drop", 32'(in_ready), 32'd0);
    wait_out(lat);
    chk("latency", 32'(lat), 32'd9);
    chk("first_product", 32'(product), 32'h0000_FFF1);
    step();
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      send(ca[i], cb[i], ce[i]);
      wait_out(lat);
      chk("corner_latency", 32'(lat), 32'd9);
      step();
    end

    // Backpressure: hold DONE for 5 cycles while offering a new operand pair
    out_ready = 1'b0;
    send(8'd7, 8'hFA, 16'hFFD6);
    wait_out(lat);
    step();
    in_valid = 1'b1;
    muld = 8'd1;
    mulr = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_product", 32'(product), 32'h0000_FFD6);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    step();

    // Operand change during CALC is ignored; the held request waits for in_ready
    send(8'd3, 8'd4, 16'h000C);
    send(8'hF9, 8'd9, 16'hFFC1);
    wait_out(lat);
    step();
    chk("chg_drained", 32'(sb.size()), 32'd0);

    // Reset during the fourth CALC cycle discards the operation
    send(8'd9, 8'd9, 16'h0051);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    step();
    send(8'd2, 8'd2, 16'h0004);
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'd9);
    step();

    // Random traffic with random input gaps and output backpressure
    n_in = 0;
    n_out = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          logic [DW-1:0] a, b;
          a = DW'($urandom);
          b = DW'($urandom);
          repeat ($urandom_range(0, 3)) step();
          send(a, b, ref_mul(a, b));
        end
        drv_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(drv_done && sb.size() == 0) && cyc < 60000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        if (cyc >= 60000) chk("random_timeout", 32'd0, 32'd1);
      end
    join
    out_ready = 1'b1;
    repeat (2) step();
    chk("handshake_count", 32'(n_out), 32'(n_in));
    chk("random_in_count", 32'(n_in), 32'(NRAND));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
